radar_echo_responder: RTL and testbench

//  Target-side end of the radar pulse/echo interface: watches radar_pulse_trigger, models one

---
 rtl/radar_echo_responder_pkg.sv | 21 ++
 rtl/radar_echo_responder_target_kinematics.sv | 48 ++++
 rtl/radar_echo_responder.sv | 122 ++++++++++++
 tb/tb_radar_echo_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radar_echo_responder_pkg.sv
// Constants for the radar echo responder. The radar tracking unit uses the same
// state encodings and timing so the two ends stay consistent.
package radar_echo_responder_pkg;

  typedef logic [31:0] range_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DELAY = 2'd2;
  localparam logic [1:0] ST_ECHO  = 2'd3;

  localparam range_t     M_PER_CYCLE = 32'd150;
  localparam range_t     MAX_DELAY   = 32'd2000;
  localparam range_t     SUB_PER_M   = 32'd1000000;
  localparam range_t     PULSE_WIDTH = 32'd300;
  localparam logic [3:0] ECHO_WIDTH  = 4'd10;

  // Beyond this range the echo would come back after MAX_DELAY cycles, so none is sent.
  localparam range_t     MAX_RANGE   = MAX_DELAY * M_PER_CYCLE;

endpackage

// File: rtl/radar_echo_responder_target_kinematics.sv
// Target range integrator: speed is accumulated in sub-metre units every cycle,
// and range moves by one metre on each accumulator overflow, saturating at both ends.
module target_kinematics
  import radar_echo_responder_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic [31:0] init,
  input  logic [31:0] speed,
  input  logic        closing,
  output logic [31:0] distance
);

  range_t acc_q, acc_d;
  range_t distance_q, distance_d;
  range_t acc_sum;

  assign acc_sum  = acc_q + speed;
  assign distance = distance_q;

  always_comb begin
    acc_d      = acc_sum;
    distance_d = distance_q;
    if (load) begin
      acc_d      = '0;
      distance_d = init;
    end else if (acc_sum >= SUB_PER_M) begin
      acc_d = acc_sum - SUB_PER_M;
      if (closing) begin
        if (distance_q != '0) distance_d = distance_q - 32'd1;
      end else begin
        if (distance_q != '1) distance_d = distance_q + 32'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q      <= '0;
      distance_q <= '0;
    end else begin
      acc_q      <= acc_d;
      distance_q <= distance_d;
    end
  end

endmodule

// File: rtl/radar_echo_responder.sv
// Target-side end of the radar pulse/echo link: detects the transmit pulse, counts out
// the round-trip delay for the current range and returns a fixed-width echo.
module radar_echo_responder
  import radar_echo_responder_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        radar_pulse_trigger,
  input  logic        target_enable,
  input  logic        target_load,
  input  logic [31:0] target_distance_init,
  input  logic [31:0] target_speed,
  input  logic        target_closing,
  output logic        radar_echo,
  output logic [31:0] target_distance,
  output logic [15:0] echo_count,
  output logic        out_of_range,
  output logic [1:0]  responder_state
);

  logic        trig_q, trig_d;
  logic [1:0]  state_q, state_d;
  range_t      rem_q, rem_d;
  logic [3:0]  width_cnt_q, width_cnt_d;
  logic        echo_q, echo_d;
  logic [15:0] echo_count_q, echo_count_d;
  logic        oor_q, oor_d;
  logic        rise, fall;

  target_kinematics u_kinematics (
    .CLK      (CLK),
    .RST      (RST),
    .load     (target_load),
    .init     (target_distance_init),
    .speed    (target_speed),
    .closing  (target_closing),
    .distance (target_distance)
  );

  assign rise = radar_pulse_trigger & ~trig_q;
  assign fall = ~radar_pulse_trigger & trig_q;

  assign radar_echo      = echo_q;
  assign echo_count      = echo_count_q;
  assign out_of_range    = oor_q;
  assign responder_state = state_q;

  // Range is latched on the falling edge, so target motion during the delay
  // only affects the next pulse.
  always_comb begin
    trig_d       = radar_pulse_trigger;
    state_d      = state_q;
    rem_d        = rem_q;
    width_cnt_d  = width_cnt_q;
    echo_d       = echo_q;
    echo_count_d = echo_count_q;
    oor_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (fall) begin
          if (!target_enable) begin
            state_d = ST_IDLE;
          end else if (target_distance > MAX_RANGE) begin
            oor_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rem_d   = target_distance;
            state_d = ST_DELAY;
          end
        end
      end
      ST_DELAY: begin
        if (rise) begin
          state_d = ST_ARMED;
        end else if (rem_q < M_PER_CYCLE) begin
          echo_d       = 1'b1;
          width_cnt_d  = 4'd1;
          echo_count_d = echo_count_q + 16'd1;
          state_d      = ST_ECHO;
        end else begin
          rem_d = rem_q - M_PER_CYCLE;
        end
      end
      ST_ECHO: begin
        if (rise) begin
          echo_d  = 1'b0;
          state_d = ST_ARMED;
        end else if (width_cnt_q == ECHO_WIDTH) begin
          echo_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          width_cnt_d = width_cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      trig_q       <= 1'b0;
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      width_cnt_q  <= '0;
      echo_q       <= 1'b0;
      echo_count_q <= '0;
      oor_q        <= 1'b0;
    end else begin
      trig_q       <= trig_d;
      state_q      <= state_d;
      rem_q        <= rem_d;
      width_cnt_q  <= width_cnt_d;
      echo_q       <= echo_d;
      echo_count_q <= echo_count_d;
      oor_q        <= oor_d;
    end
  end

endmodule

// File: tb/tb_radar_echo_responder.sv
// Directed bench for radar_echo_responder: echo timing, out-of-range, abort,
// enable gating, range kinematics and mid-echo reset.
module tb_radar_echo_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic        target_enable;
  logic        target_load;
  logic [31:0] target_distance_init;
  logic [31:0] target_speed;
  logic        target_closing;
  logic        radar_echo;
  logic [31:0] target_distance;
  logic [15:0] echo_count;
  logic        out_of_range;
  logic [1:0]  responder_state;

  int total_checks = 0;
  int bad_checks   = 0;

  always #5 clk = ~clk;

  radar_echo_responder dut (
    .CLK                  (clk),
    .RST                  (rst),
    .radar_pulse_trigger  (trig),
    .target_enable        (target_enable),
    .target_load          (target_load),
    .target_distance_init (target_distance_init),
    .target_speed         (target_speed),
    .target_closing       (target_closing),
    .radar_echo           (radar_echo),
    .target_distance      (target_distance),
    .echo_count           (echo_count),
    .out_of_range         (out_of_range),
    .responder_state      (responder_state)
  );

  // Inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_target(input logic [31:0] d);
    target_distance_init = d;
    target_load = 1'b1;
    tick(1);
    target_load = 1'b0;
  endtask

  task automatic send_pulse();
    trig = 1'b1;
    tick(300);
    trig = 1'b0;
  endtask

  // Sample index i corresponds to the state just after edge E0+i-1.
  task automatic watch_echo(input int window, output int first_idx, output int high_cycles,
                            output int oor_first, output int oor_cycles);
    first_idx = -1; high_cycles = 0; oor_first = -1; oor_cycles = 0;
    for (int i = 1; i <= window; i++) begin
      tick(1);
      if (radar_echo === 1'b1) begin
        if (first_idx < 0) first_idx = i;
        high_cycles++;
      end
      if (out_of_range === 1'b1) begin
        if (oor_first < 0) oor_first = i;
        oor_cycles++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    total_checks++;
    if (radar_echo !== 1'b0 || echo_count !== 16'd0 || target_distance !== 32'd0 ||
        out_of_range !== 1'b0 || responder_state !== 2'd0) begin
      bad_checks++;
      $display("[TB] FAIL reset: echo=%b cnt=%0d dist=%0d oor=%b st=%0d, need all zero",
               radar_echo, echo_count, target_distance, out_of_range, responder_state);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_basic_echo();
    int f, h, of, oc;
    load_target(32'd15000);
    send_pulse();
    watch_echo(150, f, h, of, oc);
    total_checks++;
    if (f !== 102) begin
      bad_checks++;
      $display("[TB] FAIL basic_rise: first echo sample %0d, need 102 (E0+101)", f);
    end
    total_checks++;
    if (h !== 10) begin
      bad_checks++;
      $display("[TB] FAIL basic_width: echo high %0d cycles, need 10", h);
    end
    total_checks++;
    if (echo_count !== 16'd1 || responder_state !== 2'd0 || oc !== 0) begin
      bad_checks++;
      $display("[TB] FAIL basic_count: cnt=%0d st=%0d oor=%0d, need 1/0/0",
               echo_count, responder_state, oc);
    end
  endtask

  task automatic test_out_of_range();
    int f, h, of, oc;
    load_target(32'd400000);
    send_pulse();
    watch_echo(150, f, h, of, oc);
    total_checks++;
    if (of !== 1 || oc !== 1) begin
      bad_checks++;
      $display("[TB] FAIL oor_strobe: first=%0d cycles=%0d, need 1/1", of, oc);
    end
    total_checks++;
    if (f !== -1 || echo_count !== 16'd1 || responder_state !== 2'd0) begin
      bad_checks++;
      $display("[TB] FAIL oor_no_echo: first=%0d cnt=%0d st=%0d, need -1/1/0",
               f, echo_count, responder_state);
    end
  endtask

  task automatic test_range_boundary();
    int f, h, of, oc;
    load_target(32'd300000);
    send_pulse();
    watch_echo(2100, f, h, of, oc);
    total_checks++;
    if (f !== 2002 || h !== 10 || oc !== 0) begin
      bad_checks++;
      $display("[TB] FAIL max_range: first=%0d high=%0d oor=%0d, need 2002/10/0", f, h, oc);
    end
    total_checks++;
    if (echo_count !== 16'd2) begin
      bad_checks++;
      $display("[TB] FAIL max_range_count: cnt=%0d, need 2", echo_count);
    end
  endtask

  task automatic test_abort();
    int f, h, of, oc;
    load_target(32'd150000);
    send_pulse();
    watch_echo(500, f, h, of, oc);
    total_checks++;
    if (f !== -1 || responder_state !== 2'd2) begin
      bad_checks++;
      $display("[TB] FAIL abort_delay: first=%0d st=%0d, need -1/2", f, responder_state);
    end
    send_pulse();
    watch_echo(1100, f, h, of, oc);
    total_checks++;
    if (f !== 1002 || h !== 10 || echo_count !== 16'd3) begin
      bad_checks++;
      $display("[TB] FAIL abort_repulse: first=%0d high=%0d cnt=%0d, need 1002/10/3",
               f, h, echo_count);
    end
  endtask

  task automatic test_enable_off();
    int f, h, of, oc;
    target_enable = 1'b0;
    load_target(32'd15000);
    send_pulse();
    watch_echo(150, f, h, of, oc);
    total_checks++;
    if (f !== -1 || echo_count !== 16'd3 || responder_state !== 2'd0 || oc !== 0) begin
      bad_checks++;
      $display("[TB] FAIL enable_off: first=%0d cnt=%0d st=%0d oor=%0d, need -1/3/0/0",
               f, echo_count, responder_state, oc);
    end
    target_enable = 1'b1;
  endtask

  task automatic test_kinematics();
    target_speed = 32'd100000;
    target_closing = 1'b1;
    load_target(32'd30000);
    tick(9);
    total_checks++;
    if (target_distance !== 32'd30000) begin
      bad_checks++;
      $display("[TB] FAIL kin_before_step: dist=%0d, need 30000", target_distance);
    end
    tick(1);
    total_checks++;
    if (target_distance !== 32'd29999) begin
      bad_checks++;
      $display("[TB] FAIL kin_first_step: dist=%0d, need 29999", target_distance);
    end
    tick(9990);
    total_checks++;
    if (target_distance !== 32'd29000) begin
      bad_checks++;
      $display("[TB] FAIL kin_closing: dist=%0d, need 29000", target_distance);
    end
    target_closing = 1'b0;
    tick(10000);
    total_checks++;
    if (target_distance !== 32'd30000) begin
      bad_checks++;
      $display("[TB] FAIL kin_opening: dist=%0d, need 30000", target_distance);
    end
    target_closing = 1'b1;
    tick(5);
    load_target(32'd1000);
    tick(5);
    total_checks++;
    if (target_distance !== 32'd1000) begin
      bad_checks++;
      $display("[TB] FAIL kin_load_clears_acc: dist=%0d, need 1000", target_distance);
    end
    tick(5);
    total_checks++;
    if (target_distance !== 32'd999) begin
      bad_checks++;
      $display("[TB] FAIL kin_after_load: dist=%0d, need 999", target_distance);
    end
    target_speed = 32'd500000;
    load_target(32'd2);
    tick(10);
    total_checks++;
    if (target_distance !== 32'd0) begin
      bad_checks++;
      $display("[TB] FAIL kin_sat_zero: dist=%0d, need 0", target_distance);
    end
    target_closing = 1'b0;
    load_target(32'hFFFF_FFFE);
    tick(10);
    total_checks++;
    if (target_distance !== 32'hFFFF_FFFF) begin
      bad_checks++;
      $display("[TB] FAIL kin_sat_max: dist=%h, need ffffffff", target_distance);
    end
    target_speed = 32'd0;
  endtask

  task automatic test_mid_echo_reset();
    int f, h, of, oc;
    load_target(32'd15000);
    send_pulse();
    tick(104);
    total_checks++;
    if (radar_echo !== 1'b1 || echo_count !== 16'd4) begin
      bad_checks++;
      $display("[TB] FAIL mid_reset_pre: echo=%b cnt=%0d, need 1/4", radar_echo, echo_count);
    end
    rst = 1'b1;
    tick(1);
    total_checks++;
    if (radar_echo !== 1'b0 || echo_count !== 16'd0 || target_distance !== 32'd0 ||
        responder_state !== 2'd0) begin
      bad_checks++;
      $display("[TB] FAIL mid_reset: echo=%b cnt=%0d dist=%0d st=%0d, need 0/0/0/0",
               radar_echo, echo_count, target_distance, responder_state);
    end
    rst = 1'b0;
    watch_echo(200, f, h, of, oc);
    total_checks++;
    if (f !== -1 || echo_count !== 16'd0) begin
      bad_checks++;
      $display("[TB] FAIL mid_reset_resume: first=%0d cnt=%0d, need -1/0", f, echo_count);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    trig = 1'b0;
    target_enable = 1'b1;
    target_load = 1'b0;
    target_distance_init = 32'd0;
    target_speed = 32'd0;
    target_closing = 1'b0;
    tick(1);
    test_reset();
    test_basic_echo();
    test_out_of_range();
    test_range_boundary();
    test_abort();
    test_enable_off();
    test_kinematics();
    test_mid_echo_reset();
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
